// File: rtl/alu_issue_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sequencer_if
// Description : Instruction valid/ready handshake between a host (master)
//               and the ALU issue sequencer (slave).
//               in_valid - host has an instruction on in_instr
//               in_instr - {op[8:6], dst[5:4], src_s[3:2], src_t[1:0]}
//               in_ready - sequencer can accept this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_sequencer_if;
  logic       in_valid;
  logic [8:0] in_instr;
  logic       in_ready;

  modport master (output in_valid, output in_instr, input  in_ready);
  modport slave  (input  in_valid, input  in_instr, output in_ready);
endinterface
`default_nettype wire

// File: rtl/alu_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_sequencer
// Description : Sequential front end for a combinational ALU. Holds a
//               4 x 4-bit register file, accepts instructions over a
//               valid/ready handshake, drives operands/opcode to the ALU,
//               captures the ALU result and writes it back.
// Ports       : clk, rst_n          - clock, async active-low reset
//               wr_en/wr_addr/wr_data - host register write (IDLE only)
//               rd_addr/rd_data     - combinational debug read
//               in_if (slave)       - instruction handshake
//               exe_rs/exe_rt/exe_sel - registered operands/opcode to ALU
//               exe_rd              - ALU result (combinational from exe_*)
//               done                - one-cycle writeback pulse
//               result              - last written-back value
//               busy                - instruction in flight
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_sequencer (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 wr_en,
  input  wire logic [1:0]           wr_addr,
  input  wire logic [3:0]           wr_data,
  input  wire logic [1:0]           rd_addr,
  output logic      [3:0]           rd_data,
  alu_issue_sequencer_if.slave      in_if,
  output logic      [3:0]           exe_rs,
  output logic      [3:0]           exe_rt,
  output logic      [2:0]           exe_sel,
  input  wire logic [3:0]           exe_rd,
  output logic                      done,
  output logic      [3:0]           result,
  output logic                      busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] regs_q [4];
  logic [3:0] regs_d [4];
  logic [3:0] exe_rs_q, exe_rs_d;
  logic [3:0] exe_rt_q, exe_rt_d;
  logic [2:0] exe_sel_q, exe_sel_d;
  logic [1:0] dst_q, dst_d;
  logic [3:0] result_q, result_d;

  logic       accept;
  logic [2:0] instr_op;
  logic [1:0] instr_dst;
  logic [1:0] instr_src_s;
  logic [1:0] instr_src_t;

  assign instr_op    = in_if.in_instr[8:6];
  assign instr_dst   = in_if.in_instr[5:4];
  assign instr_src_s = in_if.in_instr[3:2];
  assign instr_src_t = in_if.in_instr[1:0];

  // in_ready already excludes host writes, so a write wins over accept.
  assign accept = in_if.in_valid & in_if.in_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_if.in_ready = (state_q == S_IDLE) & ~wr_en;
    done           = (state_q == S_WB);
    busy           = (state_q != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    regs_d    = regs_q;
    exe_rs_d  = exe_rs_q;
    exe_rt_d  = exe_rt_q;
    exe_sel_d = exe_sel_q;
    dst_d     = dst_q;
    result_d  = result_q;

    // Operands are sampled at accept, so dst aliasing a source reads the
    // pre-writeback value.
    if (accept) begin
      exe_rs_d  = regs_q[instr_src_s];
      exe_rt_d  = regs_q[instr_src_t];
      exe_sel_d = instr_op;
      dst_d     = instr_dst;
    end

    if (state_q == S_ISSUE) begin
      result_d = exe_rd;
    end

    if (state_q == S_WB) begin
      regs_d[dst_q] = result_q;
    end else if ((state_q == S_IDLE) && wr_en) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 4'd0;
      end
      exe_rs_q  <= 4'd0;
      exe_rt_q  <= 4'd0;
      exe_sel_q <= 3'd0;
      dst_q     <= 2'd0;
      result_q  <= 4'd0;
    end else begin
      regs_q    <= regs_d;
      exe_rs_q  <= exe_rs_d;
      exe_rt_q  <= exe_rt_d;
      exe_sel_q <= exe_sel_d;
      dst_q     <= dst_d;
      result_q  <= result_d;
    end
  end

  assign exe_rs  = exe_rs_q;
  assign exe_rt  = exe_rt_q;
  assign exe_sel = exe_sel_q;
  assign result  = result_q;
  assign rd_data = regs_q[rd_addr];

endmodule
`default_nettype wire
